// File: rtl/fifo_pkg.sv
// Shared types and constants for the nibble-packing flush FIFO and its drain stage.
package fifo_pkg;

    localparam int ROW_W        = 32;
    localparam int NIB_W        = 4;
    localparam int NIBS_PER_ROW = 8;
    localparam int COL_W        = $clog2(NIBS_PER_ROW);
    localparam logic [NIB_W-1:0] PAD_NIB = 4'hC;

    typedef struct packed {
        logic [ROW_W-1:0] data;
        logic             last;
    } row_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

endpackage

// File: rtl/row_skid_buf.sv
// Two-entry row buffer with 1-bit head/tail pointers and an occupancy count.
module row_skid_buf
    import fifo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  row_entry_t push_entry,
    input  logic       pop,
    output row_entry_t head_entry,
    output logic [1:0] occ
);

    row_entry_t mem [2];
    logic       head_q;
    logic       tail_q;
    logic [1:0] occ_q;
    logic [1:0] occ_d;

    // The caller never pushes when full or pops when empty.
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (push) tail_q <= ~tail_q;
            if (pop)  head_q <= ~head_q;
            occ_q <= occ_d;
        end
    end

    // Row storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[tail_q] <= push_entry;
    end

    assign head_entry = mem[head_q];
    assign occ        = occ_q;

endmodule

// File: rtl/fifo_row_unpacker.sv
// Drains 32-bit rows from the packing FIFO and serializes them as 4-bit nibbles,
// column 0 first; also runs the FIFO flush handshake.
module fifo_row_unpacker
    import fifo_pkg::*;
#(
    parameter int FLUSH_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_data_avail_i,
    input  logic [ROW_W-1:0]       fifo_rd_data_i,
    output logic                   fifo_rd_valid_o,
    input  logic                   fifo_flush_done_i,
    output logic                   fifo_flush_o,
    input  logic                   flush_req_i,
    output logic                   flush_busy_o,
    output logic [FLUSH_CNT_W-1:0] flush_cnt_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [NIB_W-1:0]       out_nibble_o,
    output logic                   out_last_o
);

    // Handshake: a nibble transfers on a rising clk edge where out_valid_o and
    // out_ready_i are both high; while valid is high and ready low, nibble/last hold.
    row_entry_t       head_entry;
    row_entry_t       push_entry;
    logic [1:0]       occ;
    logic [COL_W-1:0] col_q;
    logic             fire;
    logic             retire;
    logic             flush_done_pop;

    flush_state_e           state_q;
    flush_state_e           state_d;
    logic                   cnt_inc;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;

    assign fifo_rd_valid_o = fifo_data_avail_i & (occ != 2'd2);
    assign push_entry      = '{data: fifo_rd_data_i, last: fifo_flush_done_i};

    row_skid_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_rd_valid_o),
        .push_entry (push_entry),
        .pop        (retire),
        .head_entry (head_entry),
        .occ        (occ)
    );

    assign out_valid_o  = (occ != 2'd0);
    assign fire         = out_valid_o & out_ready_i;
    assign retire       = fire & (col_q == COL_W'(NIBS_PER_ROW - 1));
    assign out_nibble_o = out_valid_o ? head_entry.data[NIB_W*col_q +: NIB_W] : '0;
    assign out_last_o   = out_valid_o & head_entry.last & (col_q == COL_W'(NIBS_PER_ROW - 1));

    // Column wraps 7 -> 0 naturally as the head row retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
        end else if (fire) begin
            col_q <= col_q + 1'b1;
        end
    end

    // Done only means something in a cycle where the flushed row is actually popped.
    assign flush_done_pop = fifo_flush_done_i & fifo_rd_valid_o;

    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE:    if (flush_req_i) state_d = FLUSH;
            FLUSH: begin
                if (flush_done_pop) begin
                    state_d = IDLE;
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_inc) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign fifo_flush_o = (state_q == FLUSH);
    assign flush_busy_o = (state_q == FLUSH);
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_fifo_row_unpacker.sv
// Bench for fifo_row_unpacker: FIFO model feeding rows, scoreboard checking the nibble stream.
module tb_fifo_row_unpacker;

    localparam int FLUSH_CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   fifo_data_avail_i;
    logic [31:0]            fifo_rd_data_i;
    logic                   fifo_rd_valid_o;
    logic                   fifo_flush_done_i;
    logic                   fifo_flush_o;
    logic                   flush_req_i;
    logic                   flush_busy_o;
    logic [FLUSH_CNT_W-1:0] flush_cnt_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [3:0]             out_nibble_o;
    logic                   out_last_o;
    logic                   head_done;

    fifo_row_unpacker #(.FLUSH_CNT_W(FLUSH_CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_data_avail_i (fifo_data_avail_i),
        .fifo_rd_data_i    (fifo_rd_data_i),
        .fifo_rd_valid_o   (fifo_rd_valid_o),
        .fifo_flush_done_i (fifo_flush_done_i),
        .fifo_flush_o      (fifo_flush_o),
        .flush_req_i       (flush_req_i),
        .flush_busy_o      (flush_busy_o),
        .flush_cnt_o       (flush_cnt_o),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_nibble_o      (out_nibble_o),
        .out_last_o        (out_last_o)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // The FIFO raises done only in the pop cycle of the flushed row.
    assign fifo_flush_done_i = head_done & fifo_rd_valid_o;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          hs_first = -1;
    int          hs_last = -1;
    int          p0;
    logic [32:0] fifo_q[$];
    logic [4:0]  exp_q[$];
    logic [31:0] partial_data = 32'hCCCCCCCC;
    bit          flush_armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        if (fifo_q.size() != 0) begin
            fifo_rd_data_i    = fifo_q[0][31:0];
            head_done         = fifo_q[0][32];
            fifo_data_avail_i = 1'b1;
        end else begin
            fifo_rd_data_i    = '0;
            head_done         = 1'b0;
            fifo_data_avail_i = 1'b0;
        end
    endtask

    // Driver: queue a row in the FIFO model and its eight nibbles in the scoreboard.
    task automatic push_row(input logic [31:0] d, input logic done);
        logic [31:0] dd;
        dd = d;
        fifo_q.push_back({done, dd});
        for (int k = 0; k < 8; k++) exp_q.push_back({done && (k == 7), dd[4*k +: 4]});
        refresh();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        flush_armed = 1'b0;
        refresh();
    endtask

    // FIFO model: pops on rd_valid, delivers the padded flush row once fifo_flush_o is seen.
    task automatic fifo_model();
        bit pop_now;
        forever begin
            @(negedge clk);
            pop_now = fifo_rd_valid_o && !reset;
            @(posedge clk);
            #1;
            cyc++;
            if (pop_now && fifo_q.size() != 0) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            if (fifo_flush_o && !flush_armed) begin
                flush_armed = 1'b1;
                push_row(partial_data, 1'b1);
            end else if (!fifo_flush_o) begin
                flush_armed = 1'b0;
            end
            refresh();
        end
    endtask

    // Monitor: pops the expected queue on every accepted nibble; protocol checks.
    task automatic monitor();
        logic [4:0] e;
        bit         done_d1;
        done_d1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_d1 = 1'b0;
            end else begin
                if (out_valid_o && out_ready_i) begin
                    hs_count++;
                    if (hs_first < 0) hs_first = cyc;
                    hs_last = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_nibble: got %0h expected none", out_nibble_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("nibble_last", {27'd0, out_last_o, out_nibble_o}, {27'd0, e});
                    end
                end
                if (fifo_rd_valid_o) chk("pop_without_avail", 32'(fifo_data_avail_i), 32'd1);
                if (done_d1) chk("flush_strobe_drop", 32'(fifo_flush_o), 32'd0);
                done_d1 = fifo_flush_done_i;
            end
        end
    endtask

    initial begin
        out_ready_i = 1'b0;
        flush_req_i = 1'b0;
        apply_reset();
        fork
            fifo_model();
            monitor();
        join_none

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_nibble", 32'(out_nibble_o), 32'd0);
        chk("rst_out_last", 32'(out_last_o), 32'd0);
        chk("rst_rd_valid", 32'(fifo_rd_valid_o), 32'd0);
        chk("rst_flush", 32'(fifo_flush_o), 32'd0);
        chk("rst_busy", 32'(flush_busy_o), 32'd0);
        chk("rst_cnt", 32'(flush_cnt_o), 32'd0);
        reset = 1'b0;
        step();

        // Two full rows back to back, no bubbles
        out_ready_i = 1'b1;
        hs_count = 0;
        hs_first = -1;
        p0 = pops;
        push_row(32'h76543210, 1'b0);
        push_row(32'hFEDCBA98, 1'b0);
        wait_drain(60);
        repeat (3) step();
        chk("t1_pops", 32'(pops - p0), 32'd2);
        chk("t1_hs_count", 32'(hs_count), 32'd16);
        chk("t1_no_bubble", 32'(hs_last - hs_first), 32'd15);

        // Consumer stall with avail held high
        out_ready_i = 1'b0;
        p0 = pops;
        push_row(32'h13579BDF, 1'b0);
        push_row(32'h2468ACE0, 1'b0);
        push_row(32'h0F0F0F0F, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 2) chk("t2_stall_hold", {27'd0, out_valid_o, out_nibble_o}, {27'd0, 1'b1, 4'hF});
        end
        chk("t2_pops_stalled", 32'(pops - p0), 32'd2);
        chk("t2_rd_valid_low", 32'(fifo_rd_valid_o), 32'd0);
        out_ready_i = 1'b1;
        wait_drain(100);
        repeat (2) step();
        chk("t2_pops_total", 32'(pops - p0), 32'd3);

        // Flush of a 3-nibble partial row
        p0 = pops;
        partial_data = 32'hCCCCC321;
        flush_req_i = 1'b1;
        step();
        flush_req_i = 1'b0;
        chk("t3_flush_high", 32'(fifo_flush_o), 32'd1);
        chk("t3_busy_high", 32'(flush_busy_o), 32'd1);
        for (int n = 0; n < 30 && flush_busy_o; n++) step();
        chk("t3_flush_timeout", 32'(flush_busy_o), 32'd0);
        chk("t3_flush_low", 32'(fifo_flush_o), 32'd0);
        chk("t3_cnt", 32'(flush_cnt_o), 32'd1);
        wait_drain(40);
        step();
        chk("t3_pops", 32'(pops - p0), 32'd1);

        // Flush behind two full rows, with a re-pulse during FLUSH
        out_ready_i = 1'b0;
        p0 = pops;
        partial_data = 32'hCCCCCCC5;
        push_row(32'h89ABCDEF, 1'b0);
        push_row(32'h01234567, 1'b0);
        flush_req_i = 1'b1;
        step();
        flush_req_i = 1'b0;
        repeat (4) step();
        chk("t4_busy_held", 32'(flush_busy_o), 32'd1);
        chk("t4_pops_stalled", 32'(pops - p0), 32'd2);
        flush_req_i = 1'b1;
        step();
        flush_req_i = 1'b0;
        step();
        chk("t4_busy_repulse", 32'(flush_busy_o), 32'd1);
        out_ready_i = 1'b1;
        wait_drain(100);
        repeat (5) step();
        chk("t4_cnt", 32'(flush_cnt_o), 32'd2);
        chk("t4_busy_low", 32'(flush_busy_o), 32'd0);
        chk("t4_flush_low", 32'(fifo_flush_o), 32'd0);
        chk("t4_pops", 32'(pops - p0), 32'd3);

        // Reset with 1.5 rows buffered
        out_ready_i = 1'b0;
        push_row(32'h87654321, 1'b0);
        push_row(32'h0BADF00D, 1'b0);
        repeat (3) step();
        out_ready_i = 1'b1;
        repeat (4) step();
        out_ready_i = 1'b0;
        apply_reset();
        step();
        chk("t5_out_valid", 32'(out_valid_o), 32'd0);
        chk("t5_out_nibble", 32'(out_nibble_o), 32'd0);
        chk("t5_out_last", 32'(out_last_o), 32'd0);
        chk("t5_rd_valid", 32'(fifo_rd_valid_o), 32'd0);
        chk("t5_flush", 32'(fifo_flush_o), 32'd0);
        chk("t5_busy", 32'(flush_busy_o), 32'd0);
        chk("t5_cnt", 32'(flush_cnt_o), 32'd0);
        reset = 1'b0;
        step();
        p0 = pops;
        out_ready_i = 1'b1;
        push_row(32'h9E3A5B7C, 1'b0);
        wait_drain(40);
        step();
        chk("t5_pops", 32'(pops - p0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_row_unpacker.md
# fifo_row_unpacker

Downstream drain stage for the nibble-packing flush FIFO. Pops 32-bit rows whenever the FIFO reports data available, buffers up to two rows, and serializes each row as eight 4-bit nibbles on a valid/ready stream, column 0 first. Also owns the FIFO flush handshake: it converts a one-cycle flush request into a held flush strobe and tags the final nibble of the flushed row with `out_last_o`.

## Interface
- `FLUSH_CNT_W`, default 8: width of the completed-flush counter.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `fifo_data_avail_i`  in  1  FIFO has a full row, or a flush row is pending.
- `fifo_rd_data_i`  in  32  head row, combinational from FIFO; nibble k = bits [4k+3:4k].
- `fifo_rd_valid_o`  out  1  pop strobe; row is consumed at this clock edge.
- `fifo_flush_done_i`  in  1  combinational from FIFO; high in the pop cycle of the flushed (padded) row.
- `fifo_flush_o`  out  1  flush strobe to FIFO, held until done.
- `flush_req_i`  in  1  single-cycle flush request from control.
- `flush_busy_o`  out  1  flush outstanding.
- `flush_cnt_o`  out  FLUSH_CNT_W  completed flushes, wraps.
- `out_valid_o`  out  1  nibble valid.
- `out_ready_i`  in  1  consumer ready.
- `out_nibble_o`  out  4  nibble data.
- `out_last_o`  out  1  final nibble (column 7) of a flushed row.

## Operation
- Row buffer: 2 entries (data[31:0] + last flag), head/tail 1-bit pointers, occupancy counter 0..2.
- Pop: `fifo_rd_valid_o = fifo_data_avail_i & (occ != 2)`. Never assert without avail; the FIFO advances its read pointer on any `rd_valid`. On a pop, write `fifo_rd_data_i` to the tail entry, with last flag = `fifo_flush_done_i` sampled in the same cycle.
- Serializer: 3-bit column index `col`. `out_valid_o = (occ != 0)`, `out_nibble_o = head.data[4*col +: 4]`, `out_last_o = out_valid_o & head.last & (col == 7)`.
- On `out_valid_o & out_ready_i`: `col` increments. At `col == 7`, the head entry retires, the head pointer toggles, and `col` wraps to 0.
- Simultaneous pop and retire: occupancy is unchanged. Pad nibbles (0xC) are emitted unchanged; stripping them is the consumer's job.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH on `flush_req_i`; `fifo_flush_o` rises the next cycle.
  - FLUSH -> IDLE on `fifo_flush_done_i`; `fifo_flush_o` drops the next cycle. It must not stay high past that cycle, or the FIFO would re-arm a second flush.
  - `flush_cnt_o` increments on the FLUSH->IDLE transition.
  - `flush_req_i` while in FLUSH is ignored, not queued.
- `flush_busy_o = (state == FLUSH)`.

## Timing
- Reset values: all outputs 0, occ = 0, col = 0, state IDLE, counter 0. Buffer data is not reset.
- Reset mid-operation discards buffered rows and any pending flush. FIFO reset is shared, so both sides restart empty.
- Pop-to-first-nibble latency: 1 cycle (data registered).
- Steady-state throughput: 1 nibble/cycle with `out_ready_i` held high. The next row is popped during the current row's serialization, so there are no bubbles between rows.
- `out_nibble_o` / `out_valid_o` / `out_last_o` are stable while `out_valid_o & ~out_ready_i`.
- `fifo_rd_valid_o` depends combinationally only on `fifo_data_avail_i` and registered state, not on `out_ready_i`.
- Flush strobe: asserted 1 cycle after `flush_req_i`; deasserted 1 cycle after the `fifo_flush_done_i` pop cycle.

## Structure
- Shared package `fifo_pkg`:
  - `ROW_W = 32`, `NIB_W = 4`, `NIBS_PER_ROW = 8`, `PAD_NIB = 4'hC`.
  - typedef `row_entry_t` (data, last).
  - enum `flush_state_e` {IDLE, FLUSH}.
- One sub-module: `row_skid_buf`, the 2-entry row buffer (push/pop/occ). The serializer and flush FSM stay in the top level.

## Test plan
- Two full rows 0x76543210, 0xFEDCBA98 with ready high -> nibbles 0,1,...,F on 16 consecutive cycles, `out_last_o` never high, exactly 2 pops.
- Consumer stalls (`out_ready_i` low) for 20 cycles with avail high -> exactly 2 pops, then `fifo_rd_valid_o` held low; output nibble held stable through the stall.
- Write 3 nibbles 1,2,3, pulse `flush_req_i` -> `fifo_flush_o` high; popped row 0xCCCCC321 emits 1,2,3,C,C,C,C,C with `out_last_o` on the 8th; `fifo_flush_o` low 1 cycle after done; `flush_cnt_o` = 1.
- Flush with 2 full rows ahead of a partial row -> 3 pops, last flag set only on the third row; `flush_req_i` re-pulsed during FLUSH leaves `flush_cnt_o` = 1.
- Assert reset while 1.5 rows are buffered -> all outputs 0 next cycle; a fresh row afterwards serializes from column 0.
- Bench assertion: `fifo_rd_valid_o` is never high while `fifo_data_avail_i` is low, and `fifo_flush_o` is never high 2 cycles after `fifo_flush_done_i`.
